// File: rtl/rx_frame_ctrl_pkg.sv
// Shared definitions for the UART receive frame controller: state encoding,
// legal oversampling ratios and bit-position helpers.
package rx_frame_ctrl_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } rx_state_t;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam int         DATA_BITS = 8;
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);

    // Last oversample of a bit period.
    function automatic logic edge_is_last(input logic [4:0] e, input logic [5:0] p);
        return ({1'b0, e} == (p - 6'd1));
    endfunction

    // Mid-bit oversample, where the sampler's vote is valid.
    function automatic logic edge_is_mid(input logic [4:0] e, input logic [5:0] p);
        return ({1'b0, e} == (p >> 1));
    endfunction

endpackage

// File: rtl/rx_edge_bit_cnt.sv
// Oversample (edge) counter and data-bit index for the receive controller.
module rx_edge_bit_cnt
    import rx_frame_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       SRST,
    input  logic       cnt_en,
    input  logic       bit_inc_en,
    input  logic [5:0] Prescale,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt
);

    always_ff @(posedge clk) begin
        if (SRST || !cnt_en) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 4'd0;
        end else begin
            edge_cnt <= edge_is_last(edge_cnt, Prescale) ? 5'd0 : edge_cnt + 5'd1;
            if (bit_inc_en) begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART receive frame controller: start-bit qualification, data/parity/stop
// sequencing, error flags and a one-cycle data_valid strobe.
module rx_frame_ctrl
    import rx_frame_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       SRST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [5:0] Prescale,
    input  logic       sampled_bit,
    input  logic [7:0] P_DATA,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err
);

    rx_state_t  state_reg, state_next;
    logic       par_en_reg, par_typ_reg;
    logic [5:0] presc_reg;
    logic       par_err_reg, stp_err_reg, data_valid_reg;
    logic       edge_last, edge_mid, start_frame, cnt_en, bit_inc_en;

    assign edge_last   = edge_is_last(edge_cnt, presc_reg);
    assign edge_mid    = edge_is_mid(edge_cnt, presc_reg);
    assign start_frame = (state_reg == ST_IDLE) && !RX_IN;
    // Counter runs only while staying inside a frame, so it reads 0 on START entry and in IDLE.
    assign cnt_en      = (state_reg != ST_IDLE) && (state_next != ST_IDLE);
    assign bit_inc_en  = (state_reg == ST_DATA) && edge_last;

    rx_edge_bit_cnt u_cnt (
        .clk        (clk),
        .SRST       (SRST),
        .cnt_en     (cnt_en),
        .bit_inc_en (bit_inc_en),
        .Prescale   (presc_reg),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt)
    );

    always_comb begin
        state_next  = state_reg;
        dat_samp_en = 1'b0;
        deser_en    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!RX_IN) state_next = ST_START;
            end
            ST_START: begin
                dat_samp_en = 1'b1;
                if (edge_mid && sampled_bit) state_next = ST_IDLE;
                else if (edge_last)          state_next = ST_DATA;
            end
            ST_DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = 1'b1;
                if (edge_last && (bit_cnt == LAST_BIT)) begin
                    state_next = par_en_reg ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                dat_samp_en = 1'b1;
                if (edge_last) state_next = ST_STOP;
            end
            ST_STOP: begin
                dat_samp_en = 1'b1;
                if (edge_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (SRST) begin
            state_reg      <= ST_IDLE;
            par_en_reg     <= 1'b0;
            par_typ_reg    <= 1'b0;
            presc_reg      <= PRESCALE_8;
            par_err_reg    <= 1'b0;
            stp_err_reg    <= 1'b0;
            data_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            // stp_err is already settled at mid-stop, before the last edge.
            data_valid_reg <= (state_reg == ST_STOP) && edge_last && !par_err_reg && !stp_err_reg;
            if (start_frame) begin
                par_en_reg  <= PAR_EN;
                par_typ_reg <= PAR_TYP;
                presc_reg   <= Prescale;
                par_err_reg <= 1'b0;
                stp_err_reg <= 1'b0;
            end
            if ((state_reg == ST_PARITY) && edge_mid) begin
                par_err_reg <= sampled_bit ^ (^P_DATA) ^ par_typ_reg;
            end
            if ((state_reg == ST_STOP) && edge_mid) begin
                stp_err_reg <= ~sampled_bit;
            end
        end
    end

    assign data_valid = data_valid_reg;
    assign par_err    = par_err_reg;
    assign stp_err    = stp_err_reg;

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock at Prescale x bit rate.
REQ-003 SRST  in  1  synchronous active-high reset.
REQ-004 RX_IN  in  1  serial line; idle high.
REQ-005 PAR_EN  in  1  1 = parity bit present after data.
REQ-006 PAR_TYP  in  1  0 = even, 1 = odd.
REQ-007 Prescale  in  6  oversampling ratio; legal values are 8, 16 and 32; other values give undefined behaviour.
REQ-008 sampled_bit  in  1  majority-voted bit from the sampler; valid when edge_cnt == Prescale>>1.
REQ-009 P_DATA  in  8  parallel byte from the deserializer, LSB first.
REQ-010 edge_cnt  out  5  oversample counter within the current bit.
REQ-011 bit_cnt  out  4  data-bit index, 0..7.
REQ-012 dat_samp_en  out  1  sampler enable.
REQ-013 deser_en  out  1  deserializer shift enable.
REQ-014 data_valid  out  1  one-cycle pulse: P_DATA holds a good frame.
REQ-015 par_err  out  1  parity mismatch on the last frame.
REQ-016 stp_err  out  1  stop bit sampled low on the last frame.

Function
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-018 In IDLE, RX_IN==0 SHALL cause a move to START with edge_cnt=0, bit_cnt=0, par_err=0 and stp_err=0.
REQ-019 Outside IDLE, edge_cnt SHALL count 0..Prescale-1 and wrap to 0; each bit period SHALL last exactly Prescale cycles.
REQ-020 In IDLE, edge_cnt SHALL hold 0.
REQ-021 dat_samp_en SHALL be 1 in every state except IDLE.
REQ-022 deser_en SHALL be 1 only in DATA.
REQ-023 START: sampled_bit==1 at edge_cnt==Prescale>>1 is a glitch and SHALL force a return to IDLE on the next cycle, with no error flags set.
REQ-024 START: otherwise, at edge_cnt==Prescale-1 the FSM SHALL move to DATA.
REQ-025 DATA: at edge_cnt==Prescale-1, bit_cnt SHALL increment.
REQ-026 DATA: at edge_cnt==Prescale-1 with bit_cnt==7, bit_cnt SHALL return to 0 and the FSM SHALL move to PARITY if PAR_EN==1, else to STOP.
REQ-027 PARITY: at edge_cnt==Prescale>>1, par_err SHALL be registered as sampled_bit XOR (^P_DATA XOR PAR_TYP).
REQ-028 PARITY: at edge_cnt==Prescale-1 the FSM SHALL move to STOP.
REQ-029 STOP: at edge_cnt==Prescale>>1, stp_err SHALL be registered as ~sampled_bit.
REQ-030 STOP: at edge_cnt==Prescale-1 the FSM SHALL move to IDLE.
REQ-031 data_valid SHALL pulse high for exactly one cycle on the cycle after STOP ends, only if par_err==0 and stp_err==0.
REQ-032 par_err and stp_err SHALL hold their values until the next START entry or SRST.
REQ-033 PAR_EN, PAR_TYP and Prescale SHALL be sampled only on IDLE->START; changes mid-frame SHALL NOT affect the current frame.
REQ-034 Back-to-back frames: a falling RX_IN while in the IDLE cycle after STOP SHALL start the next frame; a start bit up to 1 cycle late is tolerated.

Reset
REQ-035 SRST high at a rising clk edge SHALL, from any state including mid-frame, set state=IDLE and set edge_cnt, bit_cnt, dat_samp_en, deser_en, data_valid, par_err and stp_err to 0.
REQ-036 SRST SHALL have priority over all other events in the same cycle.

Structure
REQ-037 A shared package SHALL hold the state encoding (3-bit localparams), PRESCALE_8/16/32 constants and the data-bit count (8).
REQ-038 The edge/bit counter SHALL be a sub-module, rx_edge_bit_cnt, with inputs clk, SRST, cnt_en, bit_inc_en and Prescale, and outputs edge_cnt and bit_cnt.

Verification
REQ-039 Prescale=8, PAR_EN=0, byte 0xA5 -> deser_en high for 64 cycles; data_valid high one cycle, 80 cycles after START entry; P_DATA=0xA5; no errors.
REQ-040 Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C, parity bit 0 -> data_valid pulse; par_err=0.
REQ-041 Prescale=16, PAR_EN=1, PAR_TYP=1, byte 0x3C, parity bit 0 -> par_err=1; no data_valid.
REQ-042 Prescale=32, byte 0xFF, stop bit driven 0 -> stp_err=1; no data_valid; the next good frame clears stp_err at START.
REQ-043 Prescale=8, RX_IN low for 3 cycles only -> return to IDLE after edge_cnt 4; deser_en never asserts.
REQ-044 SRST asserted with bit_cnt==4 in DATA -> all outputs 0 next cycle; the following full frame 0x5A is received correctly.
